// File: rtl/gray_btn_counter_ctrl.sv
// gray_btn_counter_ctrl: debounced push-button sequencer for an N-bit Gray/binary counter
module gray_btn_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_clr,
  input  logic             btn_auto,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             auto_mode,
  output logic             step_pulse,
  output logic             wrap
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_TC = PW'(AUTO_DIV - 1);
  typedef enum logic {MANUAL, AUTO} state_t;
  state_t state, state_nxt;
  logic [3:0] raw, lvl, hist, rise;
  logic [CW-1:0] cnt [4];
  logic [PW-1:0] pre, pre_nxt;
  logic [WIDTH-1:0] bin_nxt;
  logic step_nxt, wrap_nxt;
  // bit order doubles as priority order: clr, up, down, auto
  assign raw = {btn_auto, btn_down, btn_up, btn_clr};
  assign rise = lvl & ~hist;
  assign auto_mode = (state == AUTO);
  // debounce each button independently and keep one cycle of level history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl <= '0;
      hist <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      hist <= lvl;
      for (int k = 0; k < 4; k++) begin
        if (raw[k] == lvl[k]) cnt[k] <= '0;
        else if (cnt[k] == DB_TC) begin
          lvl[k] <= ~lvl[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + CW'(1);
      end
    end
  end
  // fixed-priority arbitration, mode transitions and prescaler; manual requests preempt an auto tick
  always_comb begin
    state_nxt = state;
    bin_nxt = bin_out;
    pre_nxt = pre;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (rise[0]) begin
      bin_nxt = '0;
      step_nxt = |bin_out;
      state_nxt = MANUAL;
      pre_nxt = '0;
    end else if (rise[1] || rise[2]) begin
      bin_nxt = rise[1] ? bin_out + WIDTH'(1) : bin_out - WIDTH'(1);
      step_nxt = 1'b1;
      wrap_nxt = rise[1] ? &bin_out : ~|bin_out;
      pre_nxt = '0;
    end else if (rise[3]) begin
      state_nxt = (state == AUTO) ? MANUAL : AUTO;
      pre_nxt = '0;
    end else if (state == AUTO) begin
      step_nxt = (pre == PRE_TC);
      bin_nxt = step_nxt ? bin_out + WIDTH'(1) : bin_out;
      wrap_nxt = step_nxt & (&bin_out);
      pre_nxt = step_nxt ? '0 : pre + PW'(1);
    end
  end
  // mode state register
  always_ff @(posedge clk) begin
    if (rst) state <= MANUAL;
    else state <= state_nxt;
  end
  // counter outputs; Gray code comes from the next binary value so both update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out <= '0;
      gray_out <= '0;
      pre <= '0;
      step_pulse <= 1'b0;
      wrap <= 1'b0;
    end else begin
      bin_out <= bin_nxt;
      gray_out <= bin_nxt ^ (bin_nxt >> 1);
      pre <= pre_nxt;
      step_pulse <= step_nxt;
      wrap <= wrap_nxt;
    end
  end
endmodule

// File: tb/tb_gray_btn_counter_ctrl.sv
// tb_gray_btn_counter_ctrl: scoreboard bench for the push-button Gray counter controller
module tb_gray_btn_counter_ctrl;
  localparam logic [3:0] CLR = 4'b0001, UP = 4'b0010, DN = 4'b0100, AU = 4'b1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btns = 4'hF;
  logic btn_up, btn_down, btn_clr, btn_auto;
  logic [3:0] gray_out, bin_out;
  logic auto_mode, step_pulse, wrap;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic am_prev = 1'b0;
  typedef struct {
    int cyc;
    logic [3:0] bin;
    logic wr;
    logic am;
    logic st;
  } exp_t;
  exp_t q[$];
  assign {btn_auto, btn_down, btn_up, btn_clr} = btns;
  gray_btn_counter_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .AUTO_DIV(8)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .btn_auto(btn_auto), .gray_out(gray_out), .bin_out(bin_out), .auto_mode(auto_mode),
    .step_pulse(step_pulse), .wrap(wrap)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input int c, input logic [3:0] b, input logic w, input logic a, input logic s);
    exp_t e;
    e.cyc = c;
    e.bin = b;
    e.wr = w;
    e.am = a;
    e.st = s;
    q.push_back(e);
  endtask
  task automatic press(input logic [3:0] m, input int hold);
    btns = m;
    repeat (hold) @(negedge clk);
    btns = 4'h0;
    repeat (6) @(negedge clk);
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask
  // monitor: every step pulse or mode change must match the head of the expected queue
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (wrap && !step_pulse) begin
        tests++;
        fails++;
        $display("FAIL wrap_without_step at cyc %0d", cyc);
      end
      if (step_pulse || auto_mode !== am_prev) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d bin=%0d auto=%0b step=%0b", cyc, bin_out, auto_mode, step_pulse);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || bin_out !== e.bin || gray_out !== (e.bin ^ (e.bin >> 1)) ||
              wrap !== e.wr || auto_mode !== e.am || step_pulse !== e.st) begin
            fails++;
            $display("FAIL event: got cyc=%0d bin=%0d gray=%b wrap=%b auto=%b step=%b, expected cyc=%0d bin=%0d gray=%b wrap=%b auto=%b step=%b",
                     cyc, bin_out, gray_out, wrap, auto_mode, step_pulse,
                     e.cyc, e.bin, e.bin ^ (e.bin >> 1), e.wr, e.am, e.st);
          end
        end
      end
      am_prev = auto_mode;
    end
  end
  initial begin
    int t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({gray_out, bin_out, auto_mode, step_pulse, wrap}), 0);
    push(cyc + 5, 4'd1, 1'b0, 1'b0, 1'b1);
    btns = UP;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    btns = 4'h0;
    repeat (6) @(negedge clk);
    check("held_through_reset_bin", int'(bin_out), 1);
    push(cyc + 5, 4'd0, 1'b0, 1'b0, 1'b1);
    press(CLR, 6);
    press(UP, 3);
    repeat (6) @(negedge clk);
    check("glitch_rejected", int'(bin_out), 0);
    push(cyc + 5, 4'd1, 1'b0, 1'b0, 1'b1);
    press(UP, 20);
    check("long_hold_one_step", int'(bin_out), 1);
    for (int i = 2; i <= 15; i++) begin
      push(cyc + 5, 4'(i), 1'b0, 1'b0, 1'b1);
      press(UP, 6);
    end
    check("bin_at_15", int'(bin_out), 15);
    check("gray_at_15", int'(gray_out), 8);
    push(cyc + 5, 4'd0, 1'b1, 1'b0, 1'b1);
    press(UP, 6);
    push(cyc + 5, 4'd15, 1'b1, 1'b0, 1'b1);
    press(DN, 6);
    push(cyc + 5, 4'd0, 1'b0, 1'b0, 1'b1);
    press(CLR, 6);
    for (int i = 1; i <= 5; i++) begin
      push(cyc + 5, 4'(i), 1'b0, 1'b0, 1'b1);
      press(UP, 6);
    end
    push(cyc + 5, 4'd0, 1'b0, 1'b0, 1'b1);
    press(CLR | UP | AU, 6);
    repeat (40) @(negedge clk);
    check("priority_bin", int'(bin_out), 0);
    check("priority_auto_off", int'(auto_mode), 0);
    for (int i = 1; i <= 3; i++) begin
      push(cyc + 5, 4'(i), 1'b0, 1'b0, 1'b1);
      press(UP, 6);
    end
    push(cyc + 5, 4'd4, 1'b0, 1'b0, 1'b1);
    press(UP | DN, 6);
    push(cyc + 5, 4'd0, 1'b0, 1'b0, 1'b1);
    press(CLR, 6);
    t = cyc + 5;
    push(t, 4'd0, 1'b0, 1'b1, 1'b0);
    push(t + 8, 4'd1, 1'b0, 1'b1, 1'b1);
    push(t + 16, 4'd2, 1'b0, 1'b1, 1'b1);
    push(t + 24, 4'd3, 1'b0, 1'b1, 1'b1);
    push(t + 29, 4'd2, 1'b0, 1'b1, 1'b1);
    push(t + 37, 4'd3, 1'b0, 1'b1, 1'b1);
    push(t + 45, 4'd4, 1'b0, 1'b1, 1'b1);
    push(t + 51, 4'd4, 1'b0, 1'b0, 1'b0);
    press(AU, 6);
    wait_until(t + 24);
    press(DN, 6);
    wait_until(t + 46);
    press(AU, 6);
    wait_until(t + 81);
    check("auto_frozen_bin", int'(bin_out), 4);
    t = cyc + 5;
    push(t, 4'd4, 1'b0, 1'b1, 1'b0);
    push(t + 8, 4'd5, 1'b0, 1'b1, 1'b1);
    push(t + 16, 4'd6, 1'b0, 1'b1, 1'b1);
    push(t + 20, 4'd0, 1'b0, 1'b0, 1'b1);
    press(AU, 6);
    wait_until(t + 15);
    press(CLR, 6);
    repeat (40) @(negedge clk);
    check("clr_in_auto_bin", int'(bin_out), 0);
    check("clr_in_auto_mode", int'(auto_mode), 0);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
